mem8_responder: RTL and testbench
=================================

MEM8_RESPONDER -- requirements
Module: mem8_responder

Interface
REQ-001 Parameter BW, default 8: data and address width in bits.
REQ-002 Parameter DEPTH, default 64: number of BW-bit memory words, 1..2^BW.
REQ-003 Parameter WAIT, default 2: wait states inserted before ack, 0..15.
REQ-004 clk  input  1: single clock, all state updates on rising edge.
REQ-005 rstn  input  1: asynchronous active-low reset.
REQ-006 req  input  1: access request from the cpu8 initiator, sampled only in IDLE.
REQ-007 we  input  1: 1 = write, 0 = read, sampled with req.
REQ-008 addr  input  BW: word address, sampled with req.
REQ-009 wdata  input  BW: write data (cpu8 dout), sampled with req.
REQ-010 rdata  output  BW: read data (cpu8 din), registered.
REQ-011 ack  output  1: one-cycle completion strobe, registered.
REQ-012 err  output  1: out-of-range flag, valid only while ack=1.
REQ-013 busy  output  1: high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, WAIT and RESP; busy SHALL be 1 in WAIT and RESP.
REQ-015 IDLE with req=1 at edge k: latch we/addr/wdata, load cnt=WAIT, go to WAIT.
REQ-016 IDLE with req=0: stay in IDLE; outputs hold.
REQ-017 WAIT with cnt>0: decrement cnt at each edge.
REQ-018 WAIT with cnt=0 at an edge: perform the access, set ack=1, go to RESP; ack SHALL therefore be high during the cycle after edge k+WAIT+1.
REQ-019 RESP: at the next edge clear ack and err and return to IDLE; a request is never accepted in the same edge as leaving RESP.
REQ-020 Minimum spacing between accepted requests SHALL be WAIT+3 cycles.
REQ-021 Read, latched addr<DEPTH: rdata <= mem[addr] at the ack edge; err=0.
REQ-022 Write, latched addr<DEPTH: mem[addr] <= wdata at the ack edge; rdata unchanged; err=0.
REQ-023 Latched addr>=DEPTH: no memory update; on read rdata <= all-ones; on write rdata unchanged; err=1 with ack.
REQ-024 rdata SHALL hold its value between reads.
REQ-025 Changes on req/we/addr/wdata while busy=1 SHALL be ignored; the latched values govern the access.
REQ-026 A read following a write to the same address SHALL return the written value.
REQ-027 WAIT=0 SHALL give ack in the cycle after edge k+1 (single-cycle wait path).

Reset
REQ-028 rstn=0 SHALL immediately force state IDLE, cnt=0, ack=0, err=0, busy=0, rdata=0.
REQ-029 Reset during WAIT or RESP SHALL abort the access with no memory write and no ack.
REQ-030 Memory contents SHALL NOT be modified by rstn.
REQ-031 First request is accepted at the first rising edge with rstn=1 and req=1.

Verification
REQ-032 WAIT=2: write addr=5 wdata=8'h3C with req for one cycle at edge k -> busy=1 from k, ack=1, err=0 for exactly one cycle after edge k+3, then busy=0.
REQ-033 Read addr=5 after the REQ-032 write -> ack after edge k+3 with rdata=8'h3C; rdata still 8'h3C ten cycles later.
REQ-034 DEPTH=64: read addr=8'd64 -> ack with err=1, rdata=8'hFF; then write addr=8'd70 data 8'h11 -> err=1, and a read of addr=6 returns its prior value.
REQ-035 Change addr from 5 to 9 during WAIT -> access completes on addr 5.
REQ-036 Hold req=1 continuously -> acks spaced exactly WAIT+3 cycles apart.
REQ-037 Assert rstn=0 mid-WAIT of a write to addr 7 (prior value 8'h00) -> all outputs 0 immediately, no ack; a later read of addr 7 returns 8'h00.

Source files
------------

// File: rtl/mem8_responder.sv
// ============================================================================
// Module   : mem8_responder
// Brief    : Wait-state memory target for the cpu8 bus: latches a request,
//            inserts WAIT cycles, then completes with a one-cycle ack.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem8_responder #(
    parameter int BW    = 8,
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req,
    input  logic          we,
    input  logic [BW-1:0] addr,
    input  logic [BW-1:0] wdata,
    output logic [BW-1:0] rdata,
    output logic          ack,
    output logic          err,
    output logic          busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [BW:0] c_DEPTH = (BW + 1)'(DEPTH);

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [BW-1:0] r_addr;
    logic [BW-1:0] r_wdata;
    logic [BW-1:0] r_mem [DEPTH];

    logic          w_in_range;
    logic          w_access;
    logic [AW-1:0] w_idx;

    // Extra MSB keeps the range check correct when DEPTH equals 2**BW.
    assign w_in_range = ({1'b0, r_addr} < c_DEPTH);
    assign w_access   = (r_state == ST_WAIT) && (r_cnt == 4'd0);
    assign w_idx      = r_addr[AW-1:0];
    assign busy       = (r_state != ST_IDLE);

    // Storage has no reset; an async reset drops the state to IDLE, which
    // removes any pending write enable before the next edge.
    always_ff @(posedge clk) begin
        if (w_access && r_we && w_in_range) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            rdata   <= '0;
            ack     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_cnt   <= 4'(WAIT);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        ack     <= 1'b1;
                        err     <= ~w_in_range;
                        r_state <= ST_RESP;
                        if (!r_we) begin
                            rdata <= w_in_range ? r_mem[w_idx] : '1;
                        end
                    end
                end
                ST_RESP: begin
                    ack     <= 1'b0;
                    err     <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem8_responder.sv
// ============================================================================
// Module   : tb_mem8_responder
// Brief    : Scoreboard bench for mem8_responder (WAIT=2 main, WAIT=0 aux).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem8_responder;

    localparam int BW    = 8;
    localparam int DEPTH = 64;
    localparam int WAIT  = 2;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rstn;
    logic       req, we;
    logic [7:0] addr, wdata, rdata;
    logic       ack, err, busy;

    logic       req0, we0;
    logic [7:0] addr0, wdata0, rdata0;
    logic       ack0, err0, busy0;

    int         n_vec;
    int         n_err;
    exp_t       sb[$];
    logic [7:0] mdl_mem [256];
    logic [7:0] mdl_rdata;

    mem8_responder #(.BW(BW), .DEPTH(DEPTH), .WAIT(WAIT)) u_dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
    );

    mem8_responder #(.BW(BW), .DEPTH(DEPTH), .WAIT(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .req(req0), .we(we0), .addr(addr0),
        .wdata(wdata0), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every ack of the main DUT retires one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rdata", rdata, e.rdata);
                    check("err", err, e.err);
                end
            end
        end
    end

    function automatic void predict(input logic w, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        if (a < DEPTH) begin
            if (w) mdl_mem[a] = d;
            else   mdl_rdata  = mdl_mem[a];
            e.err = 1'b0;
        end else begin
            if (!w) mdl_rdata = 8'hFF;
            e.err = 1'b1;
        end
        e.rdata = mdl_rdata;
        sb.push_back(e);
    endfunction

    // Called #1 after an edge with the DUT idle; inputs are scrambled while busy.
    task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d);
        int n;
        predict(w, a, d);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        check("busy_after_accept", busy, 1'b1);
        req   = 1'($urandom_range(0, 1));
        we    = ~w;
        addr  = a ^ 8'h0C;
        wdata = ~d;
        n = 0;
        while (!ack && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        req = 1'b0;
        check("ack_latency", n, WAIT + 1);
        @(posedge clk); #1;
        check("ack_one_cycle", ack, 1'b0);
        check("busy_released", busy, 1'b0);
    endtask

    task automatic access0(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] exp_rd);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        @(posedge clk); #1;
        req0 = 1'b0;
        check("w0_no_ack_at_k", ack0, 1'b0);
        check("w0_busy", busy0, 1'b1);
        @(posedge clk); #1;
        check("w0_ack_at_k1", ack0, 1'b1);
        check("w0_err", err0, 1'b0);
        check("w0_rdata", rdata0, exp_rd);
        @(posedge clk); #1;
        check("w0_ack_clear", ack0, 1'b0);
        check("w0_idle", busy0, 1'b0);
    endtask

    initial begin
        int   acks;
        int   cyc;
        int   last;
        n_vec = 0; n_err = 0;
        mdl_rdata = 8'h00;
        rstn = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_rdata", rdata, 8'h00);
        check("rst_ack", ack, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rstn = 1'b1;

        // Basic write/read and hold of rdata between reads.
        access(1'b1, 8'd5, 8'h3C);
        access(1'b0, 8'd5, 8'h00);
        repeat (10) @(posedge clk);
        #1;
        check("rdata_hold", rdata, 8'h3C);

        // Out-of-range accesses and the top in-range word.
        access(1'b1, 8'd6, 8'hA5);
        access(1'b1, 8'd63, 8'h5E);
        access(1'b0, 8'd64, 8'h00);
        access(1'b1, 8'd70, 8'h11);
        access(1'b0, 8'd6, 8'h00);
        access(1'b0, 8'd63, 8'h00);

        // Address changed 5 -> 9 during WAIT must not redirect the write.
        access(1'b1, 8'd9, 8'h99);
        access(1'b1, 8'd5, 8'h77);
        access(1'b0, 8'd5, 8'h00);
        access(1'b0, 8'd9, 8'h00);

        // Continuous req: four reads, ack spacing WAIT+3.
        for (int i = 0; i < 4; i++) predict(1'b0, 8'd5, 8'h00);
        req = 1'b1; we = 1'b0; addr = 8'd5;
        acks = 0; cyc = 0; last = 0;
        while (acks < 4 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (ack) begin
                if (acks > 0) check("b2b_spacing", cyc - last, WAIT + 3);
                last = cyc;
                acks++;
                if (acks == 4) req = 1'b0;
            end
        end
        req = 1'b0;
        check("b2b_ack_count", acks, 4);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-WAIT aborts a write to addr 7.
        access(1'b1, 8'd7, 8'h00);
        req = 1'b1; we = 1'b1; addr = 8'd7; wdata = 8'h5A;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #2;
        rstn = 1'b0;
        mdl_rdata = 8'h00;
        #1;
        check("abort_rdata", rdata, 8'h00);
        check("abort_ack", ack, 1'b0);
        check("abort_err", err, 1'b0);
        check("abort_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #4;
        rstn = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 8'd7, 8'h00);

        // Zero-wait instance: ack right after edge k+1.
        access0(1'b1, 8'd3, 8'hC3, 8'h00);
        access0(1'b0, 8'd3, 8'h00, 8'hC3);

        repeat (4) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
